uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART `transmitter` between NREQ byte producers. It sits directly in front of the transmitter and drives the transmitter's `i_data` and `i_transmit` inputs. It accepts one byte at a time from requesters over a valid/ready handshake. It holds `i_transmit` for exactly one frame time per byte and enforces an idle gap between frames.

---
 rtl/uart_tx_scheduler.sv | 127 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte producers.
// Grants one byte per IDLE cycle, holds i_transmit for a full frame, then an optional idle gap.
module uart_tx_scheduler #(
    parameter int DATAWIDTH    = 8,
    parameter int NREQ         = 4,
    parameter int CLKS_PER_BIT = 10416,
    parameter int FRAME_BITS   = 10,
    parameter int GAP_CLKS     = 0
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic [NREQ-1:0]           i_req_valid,
    input  logic [NREQ*DATAWIDTH-1:0] i_req_data,
    output logic [NREQ-1:0]           o_req_ready,
    output logic [NREQ-1:0]           o_grant,
    output logic [DATAWIDTH-1:0]      o_tx_data,
    output logic                      o_tx_transmit,
    output logic                      o_busy,
    output logic                      o_frame_done
);

    localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
    localparam int MAX_CLKS   = (FRAME_CLKS > GAP_CLKS) ? FRAME_CLKS : GAP_CLKS;
    localparam int CNT_W      = $clog2(MAX_CLKS + 1);
    localparam int IDX_W      = $clog2(NREQ);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CLKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = (GAP_CLKS > 0) ? CNT_W'(GAP_CLKS - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [IDX_W-1:0]      last_grant, winner;
    logic [NREQ-1:0]       winner_oh;
    logic [NREQ-1:0]       grant;
    logic [DATAWIDTH-1:0]  tx_data;
    logic                  any_valid;
    logic                  handshake;
    logic                  frame_last;

    // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid index.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req_valid[i] && (IDX_W'(i) <= last_grant)) winner = IDX_W'(i);
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req_valid[i] && (IDX_W'(i) > last_grant)) winner = IDX_W'(i);
        end
    end

    assign any_valid  = |i_req_valid;
    assign winner_oh  = NREQ'(1) << winner;
    assign handshake  = (state == IDLE) && any_valid && !i_reset;
    assign frame_last = (state == SEND) && (cnt == FRAME_LAST);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (any_valid) state_next = SEND;
            end
            SEND: begin
                if (cnt == FRAME_LAST) begin
                    cnt_next   = '0;
                    state_next = (GAP_CLKS > 0) ? GAP : IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // last_grant resets to NREQ-1 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            tx_data    <= '0;
            grant      <= '0;
            last_grant <= IDX_W'(NREQ - 1);
        end else if (handshake) begin
            tx_data    <= i_req_data[winner*DATAWIDTH +: DATAWIDTH];
            grant      <= winner_oh;
            last_grant <= winner;
        end else if (frame_last) begin
            grant <= '0;
        end
    end

    assign o_req_ready   = handshake ? winner_oh : '0;
    assign o_grant       = grant;
    assign o_tx_data     = tx_data;
    assign o_tx_transmit = (state == SEND);
    assign o_busy        = (state != IDLE);
    assign o_frame_done  = frame_last && !i_reset;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: FRAME_CLKS=40, NREQ=4; a second instance uses GAP_CLKS=5.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready, grant;
    logic [7:0]  tx_data;
    logic        tx_transmit, busy, frame_done;

    logic [3:0]  g_valid;
    logic [31:0] g_data;
    logic [3:0]  g_ready, g_grant;
    logic [7:0]  g_tx_data;
    logic        g_tx_transmit, g_busy, g_frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.DATAWIDTH(8), .NREQ(4), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GAP_CLKS(0)) dut (
        .clk(clk), .i_reset(i_reset), .i_req_valid(req_valid), .i_req_data(req_data),
        .o_req_ready(req_ready), .o_grant(grant), .o_tx_data(tx_data),
        .o_tx_transmit(tx_transmit), .o_busy(busy), .o_frame_done(frame_done)
    );

    uart_tx_scheduler #(.DATAWIDTH(8), .NREQ(4), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GAP_CLKS(5)) dut_gap (
        .clk(clk), .i_reset(i_reset), .i_req_valid(g_valid), .i_req_data(g_data),
        .o_req_ready(g_ready), .o_grant(g_grant), .o_tx_data(g_tx_data),
        .o_tx_transmit(g_tx_transmit), .o_busy(g_busy), .o_frame_done(g_frame_done)
    );

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wait_idle(input bit which);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            cyc_start();
            sample();
            done = which ? !g_busy : !busy;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle(%0d): busy still 1 after 200 cycles, expected 0", which);
        end
    endtask

    task automatic test_reset();
        i_reset   = 1'b1;
        req_valid = 4'b1111;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        g_valid   = 4'b0000;
        g_data    = '0;
        for (int c = 0; c < 3; c++) begin
            cyc_start();
            sample();
            checks++;
            if ({req_ready, grant, tx_data, tx_transmit, busy, frame_done} !== 19'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: ready=%b grant=%b data=%h tx=%b busy=%b done=%b, expected all 0",
                         c, req_ready, grant, tx_data, tx_transmit, busy, frame_done);
            end
        end
        cyc_start();
        i_reset = 1'b0;
        sample();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_ready: got %b expected 0001", req_ready);
        end
        cyc_start();
        req_valid = 4'b0000;
        sample();
        checks++;
        if (grant !== 4'b0001 || tx_data !== 8'hA0 || tx_transmit !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: grant=%b data=%h tx=%b expected 0001/a0/1", grant, tx_data, tx_transmit);
        end
        wait_idle(0);
    endtask

    task automatic test_single();
        cyc_start();
        req_valid[2]      = 1'b1;
        req_data[23:16]   = 8'h33;
        sample();
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready_N: got %b expected 0100", req_ready);
        end
        for (int k = 1; k <= 40; k++) begin
            cyc_start();
            if (k == 1) req_valid = 4'b0000;
            sample();
            checks++;
            if (tx_transmit !== 1'b1 || tx_data !== 8'h33 || grant !== 4'b0100 ||
                req_ready !== 4'b0000 || frame_done !== (k == 40)) begin
                errors++;
                $display("FAIL single_send N+%0d: tx=%b data=%h grant=%b ready=%b done=%b expected 1/33/0100/0000/%0d",
                         k, tx_transmit, tx_data, grant, req_ready, frame_done, (k == 40));
            end
        end
        cyc_start();
        sample();
        checks++;
        if (busy !== 1'b0 || tx_transmit !== 1'b0 || tx_data !== 8'h33 || grant !== 4'b0000 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL single_after N+41: busy=%b tx=%b data=%h grant=%b done=%b expected 0/0/33/0000/0",
                     busy, tx_transmit, tx_data, grant, frame_done);
        end
    endtask

    task automatic test_all_four();
        logic [3:0] exp_oh;
        logic [7:0] exp_data;
        cyc_start();
        i_reset = 1'b1;
        cyc_start();
        i_reset   = 1'b0;
        req_valid = 4'b1111;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        sample();
        for (int f = 0; f < 5; f++) begin
            exp_oh   = 4'b0001 << (f % 4);
            exp_data = 8'hA0 + 8'(f % 4);
            if (f > 0) begin
                cyc_start();
                sample();
            end
            checks++;
            if (req_ready !== exp_oh || tx_transmit !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL all4_handshake frame %0d: ready=%b tx=%b busy=%b expected %b/0/0",
                         f, req_ready, tx_transmit, busy, exp_oh);
            end
            for (int k = 1; k <= 40; k++) begin
                cyc_start();
                if (f == 4 && k == 1) req_valid = 4'b0000;
                sample();
                checks++;
                if (tx_transmit !== 1'b1 || grant !== exp_oh || tx_data !== exp_data || frame_done !== (k == 40)) begin
                    errors++;
                    $display("FAIL all4_send frame %0d k=%0d: tx=%b grant=%b data=%h done=%b expected 1/%b/%h/%0d",
                             f, k, tx_transmit, grant, tx_data, frame_done, exp_oh, exp_data, (k == 40));
                end
            end
        end
        wait_idle(0);
    endtask

    task automatic test_late_arrival();
        cyc_start();
        req_valid[0]   = 1'b1;
        req_data[7:0]  = 8'h50;
        sample();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL late_req0_ready: got %b expected 0001", req_ready);
        end
        for (int k = 1; k <= 40; k++) begin
            cyc_start();
            if (k == 1) req_valid[0] = 1'b0;
            if (k == 10) begin
                req_valid[1]    = 1'b1;
                req_data[15:8]  = 8'h51;
            end
            if (k == 11) begin
                req_valid[3]    = 1'b1;
                req_data[31:24] = 8'h53;
            end
            sample();
            checks++;
            if (req_ready !== 4'b0000 || grant !== 4'b0001 || frame_done !== (k == 40)) begin
                errors++;
                $display("FAIL late_req0_send k=%0d: ready=%b grant=%b done=%b expected 0000/0001/%0d",
                         k, req_ready, grant, frame_done, (k == 40));
            end
        end
        cyc_start();
        sample();
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL late_req1_first: ready=%b expected 0010", req_ready);
        end
        for (int k = 1; k <= 40; k++) begin
            cyc_start();
            if (k == 1) req_valid[1] = 1'b0;
            sample();
            checks++;
            if (req_ready !== 4'b0000 || grant !== 4'b0010 || tx_data !== 8'h51) begin
                errors++;
                $display("FAIL late_req1_send k=%0d: ready=%b grant=%b data=%h expected 0000/0010/51",
                         k, req_ready, grant, tx_data);
            end
        end
        cyc_start();
        sample();
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL late_req3_next: ready=%b expected 1000", req_ready);
        end
        cyc_start();
        req_valid[3] = 1'b0;
        sample();
        checks++;
        if (grant !== 4'b1000 || tx_data !== 8'h53) begin
            errors++;
            $display("FAIL late_req3_grant: grant=%b data=%h expected 1000/53", grant, tx_data);
        end
        wait_idle(0);
    endtask

    task automatic test_reset_mid();
        cyc_start();
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'h77;
        sample();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_ready: got %b expected 0001", req_ready);
        end
        for (int k = 1; k <= 20; k++) begin
            cyc_start();
            if (k == 1) req_valid[0] = 1'b0;
            if (k == 5) begin
                req_valid[2]    = 1'b1;
                req_data[23:16] = 8'h92;
            end
            if (k == 20) i_reset = 1'b1;
            sample();
        end
        checks++;
        if (frame_done !== 1'b0 || tx_transmit !== 1'b1 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_during: done=%b tx=%b ready=%b expected 0/1/0000", frame_done, tx_transmit, req_ready);
        end
        cyc_start();
        i_reset = 1'b0;
        sample();
        checks++;
        if (tx_transmit !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000 || frame_done !== 1'b0 || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_after: tx=%b busy=%b grant=%b done=%b ready=%b expected 0/0/0000/0/0100",
                     tx_transmit, busy, grant, frame_done, req_ready);
        end
        cyc_start();
        req_valid[2] = 1'b0;
        sample();
        checks++;
        if (grant !== 4'b0100 || tx_data !== 8'h92 || tx_transmit !== 1'b1) begin
            errors++;
            $display("FAIL midrst_regrant: grant=%b data=%h tx=%b expected 0100/92/1", grant, tx_data, tx_transmit);
        end
        wait_idle(0);
    endtask

    task automatic test_gap();
        int low = 0;
        cyc_start();
        g_valid = 4'b0011;
        g_data  = {8'h00, 8'h00, 8'hC1, 8'hC0};
        sample();
        checks++;
        if (g_ready !== 4'b0001 || g_busy !== 1'b0) begin
            errors++;
            $display("FAIL gap_first_ready: ready=%b busy=%b expected 0001/0", g_ready, g_busy);
        end
        for (int k = 1; k <= 40; k++) begin
            cyc_start();
            if (k == 1) g_valid[0] = 1'b0;
            sample();
            checks++;
            if (g_tx_transmit !== 1'b1 || g_tx_data !== 8'hC0 || g_ready !== 4'b0000 || g_frame_done !== (k == 40)) begin
                errors++;
                $display("FAIL gap_send0 k=%0d: tx=%b data=%h ready=%b done=%b expected 1/c0/0000/%0d",
                         k, g_tx_transmit, g_tx_data, g_ready, g_frame_done, (k == 40));
            end
        end
        for (int c = 0; c < 20; c++) begin
            cyc_start();
            sample();
            if (g_tx_transmit) break;
            low++;
            checks++;
            if (g_grant !== 4'b0000 || g_busy !== (low <= 5) || g_frame_done !== 1'b0 ||
                g_ready !== ((low == 6) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL gap_low cycle %0d: grant=%b busy=%b done=%b ready=%b expected 0000/%0d/0/%b",
                         low, g_grant, g_busy, g_frame_done, g_ready, (low <= 5), ((low == 6) ? 4'b0010 : 4'b0000));
            end
        end
        checks++;
        if (low != 6) begin
            errors++;
            $display("FAIL gap_low_len: got %0d cycles expected 6", low);
        end
        checks++;
        if (g_grant !== 4'b0010 || g_tx_data !== 8'hC1) begin
            errors++;
            $display("FAIL gap_second_frame: grant=%b data=%h expected 0010/c1", g_grant, g_tx_data);
        end
        cyc_start();
        g_valid = 4'b0000;
        wait_idle(1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_late_arrival();
        test_reset_mid();
        test_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
